// File: rtl/alarm_response_controller_pkg.sv
// alarm_response_controller_pkg: shared state encoding and default timing constants for the alarm clock
package alarm_response_controller_pkg;
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2,
        ST_LOCKOUT = 2'd3
    } state_t;
    localparam int TIME_W               = 13;
    localparam int NUM_ALARMS           = 7;
    localparam int DEF_SNOOZE_MIN       = 9;
    localparam int DEF_MAX_SNOOZE       = 3;
    localparam int DEF_RING_TIMEOUT_MIN = 5;
    localparam int DEF_TONE_DIV         = 4;
endpackage

// File: rtl/alarm_response_controller_rise.sv
// rise_detect: registered-level rising-edge detector (one flop + AND)
module rise_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);
    logic level_d;
    // delayed copy of the level for edge comparison
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) level_d <= 1'b0;
        else          level_d <= level;
    end
    assign rise = level & ~level_d;
endmodule

// File: rtl/alarm_response_controller.sv
// alarm_response_controller: turns an aa match into a ringing session with snooze, stop, timeout and lockout
module alarm_response_controller
    import alarm_response_controller_pkg::*;
#(
    parameter int SNOOZE_MIN       = DEF_SNOOZE_MIN,
    parameter int MAX_SNOOZE       = DEF_MAX_SNOOZE,
    parameter int RING_TIMEOUT_MIN = DEF_RING_TIMEOUT_MIN,
    parameter int TONE_DIV         = DEF_TONE_DIV,
    localparam int SCW             = $clog2(MAX_SNOOZE + 1)
) (
    input  logic           clk,
    input  logic           reset_n,
    input  logic           enable,
    input  logic           aa,
    input  logic           min_tick,
    input  logic           snooze_btn,
    input  logic           stop_btn,
    output logic           buzzer,
    output logic           alarm_active,
    output logic           snoozing,
    output logic [SCW-1:0] snooze_count
);
    localparam int RTW = $clog2(RING_TIMEOUT_MIN + 1);
    localparam int STW = $clog2(SNOOZE_MIN + 1);
    localparam int TDW = $clog2(TONE_DIV + 1);
    localparam logic [SCW-1:0] CNT_MAX = SCW'(MAX_SNOOZE);
    localparam logic [RTW-1:0] RT_MAX  = RTW'(RING_TIMEOUT_MIN);
    localparam logic [RTW-1:0] RT_LAST = RTW'(RING_TIMEOUT_MIN - 1);
    localparam logic [STW-1:0] SN_INIT = STW'(SNOOZE_MIN);
    localparam logic [TDW-1:0] TD_LAST = TDW'(TONE_DIV - 1);

    state_t         state, next_state;
    logic           aa_rise, snooze_rise, stop_rise;
    logic [RTW-1:0] ring_timer, ring_timer_d;
    logic [STW-1:0] snooze_timer, snooze_timer_d;
    logic [TDW-1:0] tone, tone_d;
    logic [SCW-1:0] count_d;
    logic           buzzer_d;

    rise_detect u_aa_rise     (.clk(clk), .reset_n(reset_n), .level(aa),         .rise(aa_rise));
    rise_detect u_snooze_rise (.clk(clk), .reset_n(reset_n), .level(snooze_btn), .rise(snooze_rise));
    rise_detect u_stop_rise   (.clk(clk), .reset_n(reset_n), .level(stop_btn),   .rise(stop_rise));

    // state, timers and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            ring_timer   <= '0;
            snooze_timer <= '0;
            tone         <= '0;
            buzzer       <= 1'b0;
            alarm_active <= 1'b0;
            snoozing     <= 1'b0;
            snooze_count <= '0;
        end else begin
            state        <= next_state;
            ring_timer   <= ring_timer_d;
            snooze_timer <= snooze_timer_d;
            tone         <= tone_d;
            buzzer       <= buzzer_d;
            alarm_active <= next_state == ST_RINGING;
            snoozing     <= next_state == ST_SNOOZE;
            snooze_count <= count_d;
        end
    end

    // next state: ~enable > stop > aa re-trigger > snooze > timer expiry
    always_comb begin
        next_state = state;
        if (!enable) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:    if (aa_rise) next_state = ST_RINGING;
                ST_RINGING: begin
                    if (stop_rise)                                 next_state = ST_LOCKOUT;
                    else if (snooze_rise && snooze_count < CNT_MAX) next_state = ST_SNOOZE;
                    else if (min_tick && ring_timer >= RT_LAST)    next_state = ST_LOCKOUT;
                end
                ST_SNOOZE: begin
                    if (stop_rise)                                 next_state = ST_LOCKOUT;
                    else if (aa_rise)                              next_state = ST_RINGING;
                    else if (min_tick && snooze_timer <= STW'(1))  next_state = ST_RINGING;
                end
                ST_LOCKOUT: if (!aa) next_state = ST_IDLE;
                default:    next_state = ST_IDLE;
            endcase
        end
    end

    // timers, tone divider and snooze count; ticks only advance timers while staying in a state
    always_comb begin
        ring_timer_d   = '0;
        snooze_timer_d = '0;
        tone_d         = '0;
        buzzer_d       = 1'b0;
        count_d        = (next_state == ST_IDLE) ? '0 : snooze_count;
        if (next_state == ST_RINGING) begin
            if (state == ST_RINGING) begin
                ring_timer_d = (min_tick && ring_timer != RT_MAX) ? ring_timer + 1'b1 : ring_timer;
                tone_d       = (tone == TD_LAST) ? '0 : tone + 1'b1;
                buzzer_d     = (tone == TD_LAST) ? ~buzzer : buzzer;
            end else begin
                buzzer_d = 1'b1;
            end
        end
        if (next_state == ST_SNOOZE) begin
            if (state == ST_SNOOZE) begin
                snooze_timer_d = (min_tick && snooze_timer != '0) ? snooze_timer - 1'b1 : snooze_timer;
            end else begin
                snooze_timer_d = SN_INIT;
                count_d        = snooze_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_alarm_response_controller.sv
// tb_alarm_response_controller: directed stimulus with a session-level reference model and literal spot checks
module tb_alarm_response_controller;
    localparam int SNOOZE_MIN = 9;
    localparam int MAX_SNOOZE = 3;
    localparam int RING_TO    = 5;
    localparam int TONE_DIV   = 4;
    localparam int M_IDLE = 0, M_RING = 1, M_SNOOZE = 2, M_LOCK = 3;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       enable = 1'b1;
    logic       aa = 1'b0;
    logic       min_tick = 1'b0;
    logic       snooze_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       buzzer, alarm_active, snoozing;
    logic [1:0] snooze_count;

    int n_checks = 0;
    int n_errors = 0;

    int m_mode, m_cnt, m_ring_min, m_left, m_cyc;
    logic p_aa, p_sn, p_st, ra, rs, rt;

    alarm_response_controller dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .aa(aa), .min_tick(min_tick),
        .snooze_btn(snooze_btn), .stop_btn(stop_btn), .buzzer(buzzer),
        .alarm_active(alarm_active), .snoozing(snoozing), .snooze_count(snooze_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_tick();
        min_tick = 1'b1;
        step(1);
        min_tick = 1'b0;
        step(1);
    endtask

    task automatic press_snooze();
        snooze_btn = 1'b1;
        step(1);
        snooze_btn = 1'b0;
        step(1);
    endtask

    task automatic start_ring();
        m_mode     = M_RING;
        m_ring_min = 0;
        m_cyc      = 0;
    endtask

    // session-level reference: minutes rung, minutes left to snooze, cycles since ring start
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_mode = M_IDLE; m_cnt = 0; m_ring_min = 0; m_left = 0; m_cyc = 0;
            p_aa = 0; p_sn = 0; p_st = 0;
        end else begin
            ra = aa & ~p_aa; rs = snooze_btn & ~p_sn; rt = stop_btn & ~p_st;
            p_aa = aa; p_sn = snooze_btn; p_st = stop_btn;
            if (!enable) begin
                m_mode = M_IDLE; m_cnt = 0;
            end else if (m_mode == M_IDLE) begin
                if (ra) start_ring();
            end else if (m_mode == M_RING) begin
                if (rt) m_mode = M_LOCK;
                else if (rs && m_cnt < MAX_SNOOZE) begin
                    m_mode = M_SNOOZE; m_cnt++; m_left = SNOOZE_MIN;
                end else begin
                    m_cyc++;
                    if (min_tick) begin
                        m_ring_min++;
                        if (m_ring_min >= RING_TO) m_mode = M_LOCK;
                    end
                end
            end else if (m_mode == M_SNOOZE) begin
                if (rt) m_mode = M_LOCK;
                else if (ra) start_ring();
                else if (min_tick) begin
                    m_left--;
                    if (m_left == 0) start_ring();
                end
            end else if (!aa) begin
                m_mode = M_IDLE; m_cnt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n) begin
            check("model buzzer", int'(buzzer), int'(m_mode == M_RING && ((m_cyc / TONE_DIV) % 2 == 0)));
            check("model alarm_active", int'(alarm_active), int'(m_mode == M_RING));
            check("model snoozing", int'(snoozing), int'(m_mode == M_SNOOZE));
            check("model snooze_count", int'(snooze_count), m_cnt);
        end
    end

    initial begin
        step(2);
        check("reset buzzer", int'(buzzer), 0);
        check("reset alarm_active", int'(alarm_active), 0);
        check("reset snoozing", int'(snoozing), 0);
        check("reset count", int'(snooze_count), 0);
        reset_n = 1'b1;
        step(8);
        // 1: ring and tone
        aa = 1'b1;
        step(1);
        check("ring alarm_active", int'(alarm_active), 1);
        check("ring buzzer first", int'(buzzer), 1);
        step(3);
        check("ring buzzer still high", int'(buzzer), 1);
        step(1);
        check("ring buzzer toggled", int'(buzzer), 0);
        step(4);
        check("ring buzzer back high", int'(buzzer), 1);
        // 2: snooze and re-ring after 9 minutes
        press_snooze();
        check("snooze1 snoozing", int'(snoozing), 1);
        check("snooze1 count", int'(snooze_count), 1);
        check("snooze1 buzzer", int'(buzzer), 0);
        repeat (SNOOZE_MIN - 1) pulse_tick();
        check("snooze1 8 ticks", int'(snoozing), 1);
        pulse_tick();
        check("snooze1 re-ring", int'(alarm_active), 1);
        // 3: snooze with coincident tick, third snooze, ignored fourth
        snooze_btn = 1'b1; min_tick = 1'b1;
        step(1);
        snooze_btn = 1'b0; min_tick = 1'b0;
        step(1);
        check("snooze2 count", int'(snooze_count), 2);
        repeat (SNOOZE_MIN - 1) pulse_tick();
        check("snooze2 tick not consumed", int'(snoozing), 1);
        pulse_tick();
        check("snooze2 re-ring", int'(alarm_active), 1);
        press_snooze();
        check("snooze3 count", int'(snooze_count), 3);
        repeat (SNOOZE_MIN) pulse_tick();
        press_snooze();
        check("snooze4 ignored ringing", int'(alarm_active), 1);
        check("snooze4 ignored count", int'(snooze_count), 3);
        // 4: ring timeout, lockout while aa high, then idle
        repeat (RING_TO - 1) pulse_tick();
        check("timeout not yet", int'(alarm_active), 1);
        pulse_tick();
        check("timeout alarm off", int'(alarm_active), 0);
        check("timeout buzzer off", int'(buzzer), 0);
        step(5);
        check("lockout no re-ring", int'(alarm_active), 0);
        check("lockout count kept", int'(snooze_count), 3);
        aa = 1'b0;
        step(1);
        check("idle count cleared", int'(snooze_count), 0);
        // 5: stop beats snooze; aa re-trigger from snooze
        aa = 1'b1;
        step(1);
        check("ring again", int'(alarm_active), 1);
        snooze_btn = 1'b1; stop_btn = 1'b1;
        step(1);
        snooze_btn = 1'b0; stop_btn = 1'b0;
        step(1);
        check("stop wins alarm", int'(alarm_active), 0);
        check("stop wins snoozing", int'(snoozing), 0);
        aa = 1'b0;
        step(1);
        aa = 1'b1;
        step(2);
        press_snooze();
        check("retrig snoozing", int'(snoozing), 1);
        aa = 1'b0;
        step(1);
        aa = 1'b1;
        step(1);
        check("retrig ringing", int'(alarm_active), 1);
        check("retrig count kept", int'(snooze_count), 1);
        // 6: async reset mid-ring, enable low mid-snooze
        step(2);
        #2 reset_n = 1'b0;
        #1;
        check("async reset alarm", int'(alarm_active), 0);
        check("async reset buzzer", int'(buzzer), 0);
        check("async reset count", int'(snooze_count), 0);
        @(negedge clk);
        reset_n = 1'b1;
        step(1);
        check("post reset ring", int'(alarm_active), 1);
        press_snooze();
        enable = 1'b0;
        step(1);
        check("disable snoozing", int'(snoozing), 0);
        check("disable count", int'(snooze_count), 0);
        enable = 1'b1;
        step(3);
        check("disable stays idle", int'(alarm_active), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
